// File: rtl/bp_me_nonsynth_mem_cmd_responder.sv
// Fixed-latency responder for CCE memory commands, backed by a small zero-initialised block store.
// One command outstanding at a time; every command, legal or not, gets exactly one response.
module bp_me_nonsynth_mem_cmd_responder #(
  parameter int paddr_width_p   = 40,
  parameter int block_width_p   = 512,
  parameter int payload_width_p = 16,
  parameter int els_p           = 64,
  parameter int latency_p       = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       mem_cmd_v_i,
  output logic                       mem_cmd_ready_o,
  input  logic [3:0]                 mem_cmd_op_i,
  input  logic [paddr_width_p-1:0]   mem_cmd_addr_i,
  input  logic [2:0]                 mem_cmd_size_i,
  input  logic [payload_width_p-1:0] mem_cmd_payload_i,
  input  logic [block_width_p-1:0]   mem_cmd_data_i,
  output logic                       mem_resp_v_o,
  input  logic                       mem_resp_yumi_i,
  output logic [3:0]                 mem_resp_op_o,
  output logic [paddr_width_p-1:0]   mem_resp_addr_o,
  output logic [2:0]                 mem_resp_size_o,
  output logic [payload_width_p-1:0] mem_resp_payload_o,
  output logic [block_width_p-1:0]   mem_resp_data_o,
  output logic                       error_o
);

  localparam int block_bytes_lp = block_width_p / 8;
  localparam int off_w_lp       = $clog2(block_bytes_lp);
  localparam int idx_w_lp       = $clog2(els_p);
  localparam int cnt_w_lp       = (latency_p > 1) ? $clog2(latency_p) : 1;

  localparam logic [3:0] op_rd    = 4'd0;
  localparam logic [3:0] op_wr    = 4'd1;
  localparam logic [3:0] op_uc_rd = 4'd2;
  localparam logic [3:0] op_uc_wr = 4'd3;

  typedef enum logic [1:0] {e_idle, e_wait, e_resp} state_e;

  state_e                    state_r;
  logic [cnt_w_lp-1:0]       cnt_r;
  logic                      cmd_err_r;
  logic [block_width_p-1:0]  store_r [els_p];

  logic                      accept;
  logic [idx_w_lp-1:0]       cmd_idx, resp_idx;
  logic [31:0]               cmd_off, cmd_nbytes, resp_off, resp_nbytes;
  logic                      cmd_uc, cmd_err;
  logic [block_width_p-1:0]  wr_blk;

  assign accept = mem_cmd_v_i & mem_cmd_ready_o;

  // Builds the response data: full block for rd, zero-extended byte window for uc_rd, else zero.
  function automatic logic [block_width_p-1:0] read_block(
    input logic [3:0]               op,
    input logic [block_width_p-1:0] blk,
    input logic [31:0]              off,
    input logic [31:0]              nbytes,
    input logic                     err
  );
    logic [block_width_p-1:0] data;
    data = '0;
    if (!err && op == op_rd) data = blk;
    if (!err && op == op_uc_rd) begin
      for (int i = 0; i < block_bytes_lp; i++) begin
        if (32'(i) < nbytes) data[8*i +: 8] = blk[8*(int'(off) + i) +: 8];
      end
    end
    return data;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cmd_idx    = mem_cmd_addr_i[off_w_lp +: idx_w_lp];
    cmd_off    = 32'(mem_cmd_addr_i[off_w_lp-1:0]);
    cmd_nbytes = 32'd1 << mem_cmd_size_i;
    cmd_uc     = (mem_cmd_op_i == op_uc_rd) || (mem_cmd_op_i == op_uc_wr);
    cmd_err    = (mem_cmd_op_i > op_uc_wr)
               | (cmd_uc & ((cmd_off + cmd_nbytes) > 32'(block_bytes_lp)))
               | (cmd_uc & ((cmd_off & (cmd_nbytes - 32'd1)) != 32'd0));
    resp_idx    = mem_resp_addr_o[off_w_lp +: idx_w_lp];
    resp_off    = 32'(mem_resp_addr_o[off_w_lp-1:0]);
    resp_nbytes = 32'd1 << mem_resp_size_o;
  end

  // Merged block for a write: whole block for wr, byte window over the old contents for uc_wr.
  always_comb begin
    wr_blk = store_r[cmd_idx];
    if (mem_cmd_op_i == op_wr) wr_blk = mem_cmd_data_i;
    if (mem_cmd_op_i == op_uc_wr) begin
      for (int b = 0; b < block_bytes_lp; b++) begin
        if (32'(b) >= cmd_off && 32'(b) < cmd_off + cmd_nbytes)
          wr_blk[8*b +: 8] = mem_cmd_data_i[8*(b - int'(cmd_off)) +: 8];
      end
    end
  end

  // NOTE: the store is a model memory that must read zero after any reset, so it is cleared here.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) store_r[i] <= '0;
    end else if (accept && !cmd_err &&
                 (mem_cmd_op_i == op_wr || mem_cmd_op_i == op_uc_wr)) begin
      store_r[cmd_idx] <= wr_blk;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r            <= e_idle;
      cnt_r              <= '0;
      cmd_err_r          <= 1'b0;
      mem_cmd_ready_o    <= 1'b1;
      mem_resp_v_o       <= 1'b0;
      mem_resp_op_o      <= '0;
      mem_resp_addr_o    <= '0;
      mem_resp_size_o    <= '0;
      mem_resp_payload_o <= '0;
      mem_resp_data_o    <= '0;
      error_o            <= 1'b0;
    end else begin
      case (state_r)
        e_idle: if (accept) begin
          mem_resp_op_o      <= mem_cmd_op_i;
          mem_resp_addr_o    <= mem_cmd_addr_i;
          mem_resp_size_o    <= mem_cmd_size_i;
          mem_resp_payload_o <= mem_cmd_payload_i;
          cmd_err_r          <= cmd_err;
          error_o            <= error_o | cmd_err;
          mem_cmd_ready_o    <= 1'b0;
          if (latency_p == 1) begin
            state_r         <= e_resp;
            mem_resp_v_o    <= 1'b1;
            mem_resp_data_o <= read_block(mem_cmd_op_i, store_r[cmd_idx], cmd_off, cmd_nbytes, cmd_err);
          end else begin
            state_r <= e_wait;
            cnt_r   <= cnt_w_lp'(latency_p - 1);
          end
        end
        e_wait: begin
          if (cnt_r == '0) begin
            state_r         <= e_resp;
            mem_resp_v_o    <= 1'b1;
            mem_resp_data_o <= read_block(mem_resp_op_o, store_r[resp_idx], resp_off, resp_nbytes, cmd_err_r);
          end else begin
            cnt_r <= cnt_r - 1'b1;
          end
        end
        e_resp: if (mem_resp_yumi_i) begin
          state_r         <= e_idle;
          mem_resp_v_o    <= 1'b0;
          mem_cmd_ready_o <= 1'b1;
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    mem_resp_yumi_i |-> mem_resp_v_o);

endmodule
